// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Initiator-side controller for an asynchronous 16-bit SRAM.
//               Converts single-word read/write requests into timed
//               CE_N/OE_N/WE_N/UB_N/LB_N/address sequences and drives the
//               data-bus tristate buffer (tri_we/tri_wdata, tri_rdata).
//               Optional macro SRAM_CTRL_WR_VERIFY_EN: after every write an
//               internal read-back of the same address is performed and
//               wr_err latches on any mismatch in the enabled bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int N            = 16,
    parameter int ADDR_W       = 20,
    parameter int RD_WAIT      = 2,
    parameter int WR_PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    // request / response interface
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [N-1:0]      req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [N-1:0]      rsp_rdata,
    output logic              wr_err,
    // SRAM pins
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    // tristate buffer
    output logic              tri_we,
    output logic [N-1:0]      tri_wdata,
    input  logic [N-1:0]      tri_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } state_t;

    // Counter reload values: the counter counts down to zero inclusive,
    // so a phase of K cycles loads K-1.
    localparam logic [3:0] C_RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] C_WR_LOAD = 4'(WR_PULSE_CYC - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [1:0]        r_be;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [N-1:0]      r_rsp_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_ub_n;
    logic              r_lb_n;
    logic              r_tri_we;
    logic [N-1:0]      r_tri_wdata;

`ifdef SRAM_CTRL_WR_VERIFY_EN
    logic              r_verify;
    logic              r_wr_err;
    logic [N-1:0]      w_mask;
    logic              w_miscompare;

    // Only the bytes that were actually written take part in the compare.
    assign w_mask       = {{(N/2){r_be[1]}}, {(N/2){r_be[0]}}};
    assign w_miscompare = |((tri_rdata ^ r_tri_wdata) & w_mask);
    assign wr_err       = r_wr_err;
`else
    assign wr_err       = 1'b0;
`endif

    // Controller FSM: sequences the SRAM pins; every output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_be        <= 2'b00;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_tri_we    <= 1'b0;
            r_tri_wdata <= '0;
`ifdef SRAM_CTRL_WR_VERIFY_EN
            r_verify    <= 1'b0;
            r_wr_err    <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // req_ready is always high here, so req_valid alone accepts.
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        r_ce_n      <= 1'b0;
                        if (req_we) begin
                            r_state     <= ST_WR_SETUP;
                            r_tri_we    <= 1'b1;
                            r_tri_wdata <= req_wdata;
                            r_oe_n      <= 1'b1;
                            r_we_n      <= 1'b1;
                            r_ub_n      <= ~req_be[1];
                            r_lb_n      <= ~req_be[0];
                        end else begin
                            r_state  <= ST_RD;
                            r_cnt    <= C_RD_LOAD;
                            r_tri_we <= 1'b0;
                            r_oe_n   <= 1'b0;
                            r_we_n   <= 1'b1;
                            r_ub_n   <= 1'b0;
                            r_lb_n   <= 1'b0;
                        end
                    end
                end

                ST_RD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RD_CAP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_RD_CAP: begin
                    // tri_rdata lags the bus by one clock; by now it reflects
                    // a bus value sampled while OE_N was already low.
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_ce_n      <= 1'b1;
                    r_oe_n      <= 1'b1;
                    r_we_n      <= 1'b1;
                    r_ub_n      <= 1'b1;
                    r_lb_n      <= 1'b1;
                    r_tri_we    <= 1'b0;
`ifdef SRAM_CTRL_WR_VERIFY_EN
                    r_verify <= 1'b0;
                    if (r_verify) begin
                        if (w_miscompare) begin
                            r_wr_err <= 1'b1;
                        end
                    end else begin
                        r_rsp_rdata <= tri_rdata;
                    end
`else
                    r_rsp_rdata <= tri_rdata;
`endif
                end

                ST_WR_SETUP: begin
                    // A write with no byte enabled never pulses WE_N.
                    r_state <= ST_WR_PULSE;
                    r_cnt   <= C_WR_LOAD;
                    r_we_n  <= ~(|r_be);
                end

                ST_WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_WR_HOLD;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_WR_HOLD: begin
`ifdef SRAM_CTRL_WR_VERIFY_EN
                    // Turn the bus around and read the word back; tri_we
                    // drops on the same edge OE_N asserts.
                    r_state  <= ST_RD;
                    r_cnt    <= C_RD_LOAD;
                    r_verify <= 1'b1;
                    r_tri_we <= 1'b0;
                    r_oe_n   <= 1'b0;
                    r_we_n   <= 1'b1;
                    r_ub_n   <= 1'b0;
                    r_lb_n   <= 1'b0;
`else
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_ce_n      <= 1'b1;
                    r_oe_n      <= 1'b1;
                    r_we_n      <= 1'b1;
                    r_ub_n      <= 1'b1;
                    r_lb_n      <= 1'b1;
                    r_tri_we    <= 1'b0;
`endif
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_ce_n      <= 1'b1;
                    r_oe_n      <= 1'b1;
                    r_we_n      <= 1'b1;
                    r_ub_n      <= 1'b1;
                    r_lb_n      <= 1'b1;
                    r_tri_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign SRAM_ADDR = r_addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_UB_N = r_ub_n;
    assign SRAM_LB_N = r_lb_n;
    assign tri_we    = r_tri_we;
    assign tri_wdata = r_tri_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Self-checking bench for sram_ctrl with a behavioural SRAM
//               and a registered tristate read path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int N   = 16;
    localparam int AW  = 20;
    localparam int RDW = 2;
    localparam int WRP = 2;
    localparam int RD_LAT = RDW + 1;
`ifdef SRAM_CTRL_WR_VERIFY_EN
    localparam int WR_LAT = WRP + 2 + RDW + 1;
    localparam int WR_OE  = RDW + 1;
`else
    localparam int WR_LAT = WRP + 2;
    localparam int WR_OE  = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [N-1:0]  req_wdata;
    logic [1:0]    req_be;
    logic          rsp_valid;
    logic [N-1:0]  rsp_rdata;
    logic          wr_err;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic          tri_we;
    logic [N-1:0]  tri_wdata;
    logic [N-1:0]  tri_rdata;

    sram_ctrl #(.N(N), .ADDR_W(AW), .RD_WAIT(RDW), .WR_PULSE_CYC(WRP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_err(wr_err),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .tri_we(tri_we), .tri_wdata(tri_wdata), .tri_rdata(tri_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: 256 words indexed by the low address byte.
    logic [N-1:0] mem [256];
    logic         corrupt = 1'b0;
    logic [N-1:0] w_bus;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    assign w_bus = (!SRAM_CE_N && !SRAM_OE_N) ?
                   (mem[SRAM_ADDR[7:0]] ^ {{(N-1){1'b0}}, corrupt}) : 16'hDEAD;

    always @(posedge clk) begin
        tri_rdata <= w_bus;
        if (!SRAM_CE_N && !SRAM_WE_N && tri_we) begin
            if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= tri_wdata[15:8];
            if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= tri_wdata[7:0];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observations of one transaction.
    int            m_lat, m_we, m_oe, m_tri, m_viol;
    logic          m_ub, m_lb, m_ready0;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  m_rdata;

    // Issue one request; caller is #1 after an edge with req_ready high.
    // Returns #1 after the edge that raised rsp_valid.
    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [N-1:0] d, input logic [1:0] be);
        req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_lat = -1; m_we = 0; m_oe = 0; m_tri = 0; m_viol = 0;
        m_ub = SRAM_UB_N; m_lb = SRAM_LB_N; m_addr = SRAM_ADDR; m_ready0 = req_ready;
        m_rdata = 'x;
        for (int n = 0; n < 40; n++) begin
            if (!SRAM_WE_N) m_we++;
            if (!SRAM_OE_N) m_oe++;
            if (tri_we)     m_tri++;
            if ((!SRAM_WE_N && !SRAM_OE_N) || (tri_we && !SRAM_OE_N)) m_viol++;
            if (rsp_valid) begin
                m_lat = n;
                m_rdata = rsp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [N-1:0]  wdata;
        logic [1:0]    be;
        logic          ub_n;   // UB_N during the first busy cycle
        logic          lb_n;
        logic [N-1:0]  rdata;  // rsp_rdata at completion
    } vec_t;

    vec_t vecs [11];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [N-1:0]  wdata;
        logic [N-1:0]  rdata;
    } b2b_t;

    b2b_t ops [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 20'h12345, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 20'h12345, 16'h0000, 2'b00, 1'b0, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b1, 20'h12345, 16'hAA55, 2'b01, 1'b1, 1'b0, 16'hBEEF};
        vecs[3]  = '{1'b0, 20'h12345, 16'h0000, 2'b00, 1'b0, 1'b0, 16'hBE55};
        vecs[4]  = '{1'b1, 20'h12345, 16'h1234, 2'b10, 1'b0, 1'b1, 16'hBE55};
        vecs[5]  = '{1'b0, 20'h12345, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h1255};
        vecs[6]  = '{1'b1, 20'h12345, 16'hFFFF, 2'b00, 1'b1, 1'b1, 16'h1255};
        vecs[7]  = '{1'b0, 20'h12345, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h1255};
        vecs[8]  = '{1'b1, 20'hFFFFF, 16'h0001, 2'b11, 1'b0, 1'b0, 16'h1255};
        vecs[9]  = '{1'b0, 20'hFFFFF, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0001};
        vecs[10] = '{1'b0, 20'h00000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000};

        ops[0] = '{1'b1, 20'h00010, 16'h5A5A, 16'h0000};
        ops[1] = '{1'b0, 20'h00010, 16'h0000, 16'h5A5A};
        ops[2] = '{1'b1, 20'h00010, 16'hA5A5, 16'h0000};
        ops[3] = '{1'b0, 20'h00010, 16'h0000, 16'hA5A5};

        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b00;

        // ---------------- reset ----------------
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  {31'b0, req_ready}, 32'd1);
        chk("rst_rspv",   {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata",  {16'b0, rsp_rdata}, 32'd0);
        chk("rst_wrerr",  {31'b0, wr_err},    32'd0);
        chk("rst_addr",   {12'b0, SRAM_ADDR}, 32'd0);
        chk("rst_ctl_n",  {27'b0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rst_tri",    {15'b0, tri_we, tri_wdata}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_ctl_n", {27'b0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            chk($sformatf("v%0d_lat", i), m_lat, vecs[i].we ? WR_LAT : RD_LAT);
            chk($sformatf("v%0d_addr", i), {12'b0, m_addr}, {12'b0, vecs[i].addr});
            chk($sformatf("v%0d_ready_drop", i), {31'b0, m_ready0}, 32'd0);
            chk($sformatf("v%0d_we_cycles", i), m_we,
                (vecs[i].we && vecs[i].be != 2'b00) ? WRP : 0);
            chk($sformatf("v%0d_oe_cycles", i), m_oe, vecs[i].we ? WR_OE : RD_LAT);
            chk($sformatf("v%0d_tri_cycles", i), m_tri, vecs[i].we ? WRP + 2 : 0);
            chk($sformatf("v%0d_ub_lb", i), {30'b0, m_ub, m_lb}, {30'b0, vecs[i].ub_n, vecs[i].lb_n});
            chk($sformatf("v%0d_rdata", i), {16'b0, m_rdata}, {16'b0, vecs[i].rdata});
            chk($sformatf("v%0d_overlap", i), m_viol, 0);
            chk($sformatf("v%0d_ready_at_rsp", i), {31'b0, req_ready}, 32'd1);
        end

        // ---------------- back-to-back, req_valid held high ----------------
        begin
            int k = 0;
            int idx = 0;
            int exp_idx = -1;
            int gaps = 0;
            int viol = 0;
            req_we = ops[0].we; req_addr = ops[0].addr; req_wdata = ops[0].wdata;
            req_be = 2'b11; req_valid = 1'b1;
            @(posedge clk); #1;
            while (k < 4 && idx < 80) begin
                if ((!SRAM_WE_N && !SRAM_OE_N) || (tri_we && !SRAM_OE_N)) viol++;
                if (req_ready && !rsp_valid) gaps++;
                if (rsp_valid) begin
                    exp_idx = exp_idx + 1 + (ops[k].we ? WR_LAT : RD_LAT);
                    chk($sformatf("b2b%0d_idx", k), idx, exp_idx);
                    chk($sformatf("b2b%0d_ready", k), {31'b0, req_ready}, 32'd1);
                    if (!ops[k].we)
                        chk($sformatf("b2b%0d_rdata", k), {16'b0, rsp_rdata}, {16'b0, ops[k].rdata});
                    k++;
                    if (k < 4) begin
                        req_we = ops[k].we; req_addr = ops[k].addr; req_wdata = ops[k].wdata;
                    end else begin
                        req_valid = 1'b0;
                    end
                end
                if (k < 4) begin
                    @(posedge clk); #1;
                    idx++;
                end
            end
            req_valid = 1'b0;
            chk("b2b_count", k, 4);
            chk("b2b_gaps", gaps, 0);
            chk("b2b_overlap", viol, 0);
        end

        // ---------------- reset during WR_PULSE ----------------
        begin
            int spurious = 0;
            req_we = 1'b1; req_addr = 20'h00020; req_wdata = 16'h7777; req_be = 2'b11;
            req_valid = 1'b1;
            @(posedge clk); #1;      // WR_SETUP
            req_valid = 1'b0;
            @(posedge clk); #1;      // first WR_PULSE cycle
            chk("midrst_pulse_we_n", {31'b0, SRAM_WE_N}, 32'd0);
            reset = 1'b1;
            @(posedge clk); #1;
            chk("midrst_we_n",  {31'b0, SRAM_WE_N}, 32'd1);
            chk("midrst_tri",   {31'b0, tri_we},    32'd0);
            chk("midrst_ready", {31'b0, req_ready}, 32'd1);
            reset = 1'b0;
            for (int n = 0; n < 8; n++) begin
                if (rsp_valid) spurious++;
                @(posedge clk); #1;
            end
            chk("midrst_no_rsp", spurious, 0);
        end

        chk("wr_err_clean", {31'b0, wr_err}, 32'd0);

`ifdef SRAM_CTRL_WR_VERIFY_EN
        // ---------------- verify read-back detects corruption ----------------
        corrupt = 1'b1;
        do_req(1'b1, 20'h00030, 16'hC3C3, 2'b11);
        corrupt = 1'b0;
        chk("verify_lat", m_lat, WR_LAT);
        chk("verify_wr_err", {31'b0, wr_err}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Initiator-side controller for the asynchronous 16-bit SRAM.
- Turns single-word read/write requests from user logic into correctly timed SRAM control sequences: CE_N, OE_N, WE_N, UB_N, LB_N and address.
- Drives the SRAM data-bus tristate buffer through tri_we/tri_wdata and receives its registered read data on tri_rdata.
- Sits between Mem2IO/game logic and the tristate buffer plus the SRAM pins.

Parameters:
- N, 16, data width (SRAM word).
- ADDR_W, 20, SRAM address width.
- RD_WAIT, 2, cycles address/OE held before bus capture; legal range 1..15.
- WR_PULSE_CYC, 2, cycles WE_N held low; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  N  write data.
- req_be  in  2  byte enables, [1]=upper, [0]=lower; writes only.
- rsp_valid  out  1  one-cycle pulse on completion of any request.
- rsp_rdata  out  N  read data; valid while rsp_valid is high after a read.
- wr_err  out  1  readback mismatch flag (see Optional Feature).
- SRAM_ADDR  out  ADDR_W  SRAM address pins.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.
- tri_we  out  1  to tristate write_enabled.
- tri_wdata  out  N  to tristate data_write.
- tri_rdata  in  N  from tristate data_read; registered one clk behind the bus.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, wr_err=0, SRAM_ADDR=0, all *_N=1, tri_we=0, tri_wdata=0.
- Reset in any state returns to IDLE on the next edge. It aborts any sequence: WE_N and tri_we are deasserted and no rsp_valid is issued.
- States: IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD. A 4-bit cycle counter is used.
- Accept: req_valid && req_ready at edge E0. Address, data, be and we are latched. req_ready drops from the next cycle.
- Read: IDLE->RD.
  - RD: CE_N=0, OE_N=0, UB_N=LB_N=0, tri_we=0. Lasts RD_WAIT cycles, then RD_CAP.
  - RD_CAP: controls held for 1 cycle. At its closing edge, rsp_rdata<=tri_rdata, rsp_valid<=1 and state goes to IDLE with all controls deasserted.
  - rsp_valid is high in cycle E0+RD_WAIT+1, i.e. 3 cycles after accept at default.
- Write: IDLE->WR_SETUP.
  - WR_SETUP: 1 cycle. CE_N=0, OE_N=1, WE_N=1, tri_we=1, UB_N=~be[1], LB_N=~be[0].
  - WR_PULSE: WR_PULSE_CYC cycles with WE_N=0.
  - WR_HOLD: 1 cycle with WE_N=1; address, data and tri_we held.
  - Then IDLE with rsp_valid=1, i.e. 4 cycles after accept at default.
  - rsp_rdata is unchanged by writes.
- be=00 write: full sequence runs, WE_N never asserted, rsp_valid still issued.
- WE_N and OE_N are never simultaneously 0. tri_we is never 1 while OE_N=0.
- rsp_valid and req_ready rise in the same cycle. A new request may be accepted in that cycle, which gives back-to-back operation with no idle gap.
- req_* are ignored while req_ready=0.

Optional Feature:
- Macro: SRAM_CTRL_WR_VERIFY_EN.
- Defined: after WR_HOLD, the controller runs an internal read of the same address (RD, RD_CAP timing) before completing.
  - If the enabled bytes of tri_rdata differ from the written data, wr_err is set and stays set until reset.
  - rsp_valid is delayed to the end of the verify read; rsp_rdata is not updated.
- Undefined: no verify states exist and wr_err is tied 0.

Test Plan:
- Reset: hold reset 2 cycles -> all outputs at their reset values; req_ready=1 and all *_N=1 in the cycle after release.
- Full write: addr 0x12345, data 0xBEEF, be=11 -> SRAM_ADDR=0x12345; WE_N=0 for exactly 2 cycles; tri_we=1 for 4 cycles; UB_N=LB_N=0; rsp_valid 4 cycles after accept.
- Read back with SRAM model: read 0x12345 -> OE_N=0 for 3 cycles, WE_N=1 throughout, rsp_valid with rsp_rdata=0xBEEF 3 cycles after accept.
- Byte write: be=01, data 0xAA55 to 0x12345 -> LB_N=0, UB_N=1 during the write; subsequent read returns 0xBE55.
- Back-to-back with req_valid held high, alternating write/read -> req_ready low while busy; next accept in the rsp_valid cycle; no control overlap.
- Mid-operation reset: assert reset during WR_PULSE -> WE_N=1 and tri_we=0 next cycle; no rsp_valid. With SRAM_CTRL_WR_VERIFY_EN and the model corrupting bit 0 -> wr_err=1.
